// File: rtl/operand_stepper_pkg.sv
// Shared op-code and state definitions for the operand stepper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_stepper_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP      = 3'd0,
        OP_INC      = 3'd1,
        OP_DEC      = 3'd2,
        OP_LOAD     = 3'd3,
        OP_CLEAR    = 3'd4,
        OP_SWEEP_UP = 3'd5,
        OP_SWEEP_DN = 3'd6,
        OP_RSVD     = 3'd7   // decodes as NOP
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/operand_stepper_if.sv
// Command channel of the operand stepper: valid/ready handshake plus payload.
// Latency: n/a (wiring only).
// Backpressure: slave drives cmd_ready; a beat transfers when valid and ready are both high.
interface operand_stepper_if
    import operand_stepper_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [NCH-1:0]   cmd_mask;
    logic [WIDTH-1:0] cmd_arg;
    logic [CNT_W-1:0] cmd_count;

    modport master (output cmd_valid, cmd_op, cmd_mask, cmd_arg, cmd_count, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_op, cmd_mask, cmd_arg, cmd_count, output cmd_ready);
endinterface

// File: rtl/operand_stepper_sat_addsub.sv
// One channel's add/subtract with carry/borrow detect and optional clamp.
// Latency: combinational.
// Backpressure: none.
module sat_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_y,
    output logic             o_carry
);
    logic [WIDTH:0] w_raw;

    // Extra MSB catches carry on add and borrow (negative result) on subtract
    always_comb begin
        w_raw   = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
        o_carry = w_raw[WIDTH];
        if (i_sat && o_carry) begin
            o_y = i_sub ? '0 : '1;
        end else begin
            o_y = w_raw[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/operand_stepper.sv
// Per-channel register stepper: single-shot INC/DEC/LOAD/CLEAR and multi-cycle sweeps.
// Latency: single-shot result and done one cycle after accept; sweep done one cycle after the last step.
// Backpressure: cmd_ready low while sweeping, while en is low, and until the first edge after reset release.
module operand_stepper
    import operand_stepper_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    operand_stepper_if.slave     cmd,
    input  logic                 sat_mode,
    input  logic                 clr_flags,
    output logic [NCH*WIDTH-1:0] val,
    output logic [NCH-1:0]       ovf,
    output logic                 busy,
    output logic                 done
);
    state_e           r_state;
    op_e              r_op;
    logic [NCH-1:0]   r_mask;
    logic [WIDTH-1:0] r_step;
    logic [CNT_W-1:0] r_cnt;
    logic             r_live;
    logic [WIDTH-1:0] r_val [NCH];
    logic [NCH-1:0]   r_ovf;
    logic             r_busy;
    logic             r_done;

    op_e              w_cmd_op;
    op_e              w_cur_op;
    logic             w_run;
    logic             w_acc;
    logic             w_sweep_cmd;
    logic             w_arith;
    logic             w_sub;
    logic [WIDTH-1:0] w_cur_arg;
    logic [NCH-1:0]   w_cur_mask;
    logic [WIDTH-1:0] w_sum [NCH];
    logic [NCH-1:0]   w_carry;
    logic [NCH-1:0]   w_ovf_set;

    // Ready is held low until the first edge after reset release so it never rises asynchronously
    assign cmd.cmd_ready = en & r_live & (r_state == ST_IDLE);
    assign w_acc         = cmd.cmd_valid & cmd.cmd_ready;

    // Operand source: the incoming command when idle, the latched sweep while running
    always_comb begin
        w_cmd_op    = op_e'(cmd.cmd_op);
        w_run       = (r_state == ST_RUN);
        w_sweep_cmd = (w_cmd_op == OP_SWEEP_UP) || (w_cmd_op == OP_SWEEP_DN);
        w_cur_op    = w_run ? r_op   : w_cmd_op;
        w_cur_arg   = w_run ? r_step : cmd.cmd_arg;
        w_cur_mask  = w_run ? r_mask : cmd.cmd_mask;
        w_arith     = w_run ? en
                            : (w_acc && ((w_cmd_op == OP_INC) || (w_cmd_op == OP_DEC)));
        w_sub       = (w_cur_op == OP_DEC) || (w_cur_op == OP_SWEEP_DN);
        w_ovf_set   = w_carry & w_cur_mask & {NCH{w_arith}};
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            sat_addsub #(.WIDTH(WIDTH)) u_addsub (
                .i_a     (r_val[g]),
                .i_b     (w_cur_arg),
                .i_sub   (w_sub),
                .i_sat   (sat_mode),
                .o_y     (w_sum[g]),
                .o_carry (w_carry[g])
            );
            assign val[g*WIDTH +: WIDTH] = r_val[g];
        end
    endgenerate

    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

    // Command acceptance, sweep sequencing, channel and flag updates; en low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_mask  <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_live  <= 1'b0;
            r_ovf   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_val[i] <= '0;
            end
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            if (en) begin
                // A fresh overflow wins over a same-cycle clear
                r_ovf <= (clr_flags ? '0 : r_ovf) | w_ovf_set;
                for (int i = 0; i < NCH; i++) begin
                    if (w_arith && w_cur_mask[i]) begin
                        r_val[i] <= w_sum[i];
                    end else if (w_acc && cmd.cmd_mask[i] && (w_cmd_op == OP_LOAD)) begin
                        r_val[i] <= cmd.cmd_arg;
                    end else if (w_acc && cmd.cmd_mask[i] && (w_cmd_op == OP_CLEAR)) begin
                        r_val[i] <= '0;
                    end
                end
                if (w_acc) begin
                    if (w_sweep_cmd && (cmd.cmd_count != '0)) begin
                        r_state <= ST_RUN;
                        r_op    <= w_cmd_op;
                        r_mask  <= cmd.cmd_mask;
                        r_step  <= cmd.cmd_arg;
                        r_cnt   <= cmd.cmd_count;
                        r_busy  <= 1'b1;
                    end else begin
                        r_done <= 1'b1;
                    end
                end else if (w_run) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_operand_stepper.sv
// Self-checking bench for operand_stepper: directed corner cases plus randomized commands.
// Latency: expectations follow one-cycle single-shot and N-step sweep timing.
// Backpressure: commands are only offered while the stepper is idle.
module tb_operand_stepper;
    import operand_stepper_pkg::*;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;
    localparam int CNT_W = 8;
    localparam int MAXV  = 1 << WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 sat_mode;
    logic                 clr_flags;
    logic [NCH*WIDTH-1:0] val;
    logic [NCH-1:0]       ovf;
    logic                 busy;
    logic                 done;

    operand_stepper_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) ifc ();

    operand_stepper #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cmd       (ifc),
        .sat_mode  (sat_mode),
        .clr_flags (clr_flags),
        .val       (val),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int mval [NCH];
    bit mov  [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH*WIDTH-1:0] exp_val();
        logic [NCH*WIDTH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(mval[i]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_ovf();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = mov[i];
        return v;
    endfunction

    // Reference: one application of an op to the model, plain integer arithmetic
    task automatic m_step(input int op, input int mask, input int arg, input bit sat);
        int s;
        for (int i = 0; i < NCH; i++) begin
            if (((mask >> i) & 1) == 1) begin
                case (op)
                    1, 5: begin
                        s = mval[i] + arg;
                        if (s >= MAXV) begin mov[i] = 1; mval[i] = sat ? MAXV - 1 : s - MAXV; end
                        else mval[i] = s;
                    end
                    2, 6: begin
                        s = mval[i] - arg;
                        if (s < 0) begin mov[i] = 1; mval[i] = sat ? 0 : s + MAXV; end
                        else mval[i] = s;
                    end
                    3: mval[i] = arg;
                    4: mval[i] = 0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic drive_cmd(input int op, input int mask, input int arg, input int cnt);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = OP_W'(op);
        ifc.cmd_mask  = NCH'(mask);
        ifc.cmd_arg   = WIDTH'(arg);
        ifc.cmd_count = CNT_W'(cnt);
    endtask

    task automatic single(input int op, input int mask, input int arg, input bit sat,
                          input bit clr, input string tag);
        sat_mode  = sat;
        clr_flags = clr;
        drive_cmd(op, mask, arg, 0);
        chk({tag, "_rdy"}, 32'(ifc.cmd_ready), 1);
        step();
        ifc.cmd_valid = 1'b0;
        clr_flags     = 1'b0;
        if (clr) for (int i = 0; i < NCH; i++) mov[i] = 0;
        m_step(op, mask, arg, sat);
        chk({tag, "_val"},  32'(val),  32'(exp_val()));
        chk({tag, "_ovf"},  32'(ovf),  32'(exp_ovf()));
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic sweep(input int op, input int mask, input int arg, input int cnt, input bit sat,
                         input int gap_at, input int gap, input string tag);
        int busy_cyc, done_cnt, done_t;
        sat_mode = sat;
        drive_cmd(op, mask, arg, cnt);
        step();
        ifc.cmd_valid = 1'b0;
        for (int k = 0; k < cnt; k++) m_step(op, mask, arg, sat);
        busy_cyc = 0;
        done_cnt = 0;
        done_t   = -1;
        for (int t = 0; t < cnt + gap + 3; t++) begin
            if (busy) busy_cyc++;
            if (done) begin done_cnt++; done_t = t; end
            if (t == 0 && cnt > 0) chk({tag, "_rdy_busy"}, 32'(ifc.cmd_ready), 0);
            if (gap > 0 && t == gap_at) en = 1'b0;
            if (gap > 0 && t == gap_at + gap) en = 1'b1;
            step();
        end
        chk({tag, "_busycyc"}, 32'(busy_cyc), 32'(cnt + gap));
        chk({tag, "_donecnt"}, 32'(done_cnt), 1);
        chk({tag, "_donet"},   32'(done_t),   32'(cnt + gap));
        chk({tag, "_val"},     32'(val),      32'(exp_val()));
        chk({tag, "_ovf"},     32'(ovf),      32'(exp_ovf()));
    endtask

    initial begin
        int dn;
        int op, mask, arg;
        rst_n         = 1'b1;
        en            = 1'b1;
        sat_mode      = 1'b0;
        clr_flags     = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = '0;
        ifc.cmd_mask  = '0;
        ifc.cmd_arg   = '0;
        ifc.cmd_count = '0;
        for (int i = 0; i < NCH; i++) begin mval[i] = 0; mov[i] = 0; end
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_val",  32'(val),  0);
        chk("rst_ovf",  32'(ovf),  0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdy",  32'(ifc.cmd_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_early", 32'(ifc.cmd_ready), 0);
        step();
        chk("rel_rdy", 32'(ifc.cmd_ready), 1);

        // Wrap and saturate on channel 0 only
        single(3, 1, 250, 0, 1, "ld0");
        single(3, 2, 77,  0, 0, "ld1");
        single(1, 1, 10,  0, 0, "inc_wrap");
        chk("wrap_v0",  32'(val[7:0]),  4);
        chk("wrap_v1",  32'(val[15:8]), 77);
        chk("wrap_ovf", 32'(ovf[0]),    1);
        single(3, 1, 250, 0, 1, "ld0b");
        single(1, 1, 10,  1, 0, "inc_sat");
        chk("sat_v0",  32'(val[7:0]), 255);
        chk("sat_ovf", 32'(ovf[0]),   1);

        // Zero step leaves values and flags alone; clear racing a new overflow keeps the flag
        single(1, 3, 0, 0, 1, "zero_step");
        single(1, 1, 1, 0, 1, "clr_vs_ovf");
        chk("clr_vs_ovf_bit", 32'(ovf[0]), 1);

        // Five-step down sweep through zero
        single(3, 3, 3, 0, 1, "ld3");
        sweep(6, 3, 1, 5, 0, 0, 0, "swdn");
        chk("swdn_final", 32'(val), 32'h0000FEFE);
        chk("swdn_ovf",   32'(ovf), 3);

        // Same sweep with en dropped for three cycles in the middle
        single(3, 3, 3, 0, 1, "ld3b");
        sweep(6, 3, 1, 5, 0, 2, 3, "swdn_gap");
        chk("swdn_gap_final", 32'(val), 32'h0000FEFE);

        // Zero-count sweep completes immediately
        sweep(5, 3, 7, 0, 0, 0, 0, "sw0");

        // Reset asserted mid-sweep
        sat_mode = 1'b0;
        drive_cmd(5, 3, 1, 20);
        step();
        ifc.cmd_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NCH; i++) begin mval[i] = 0; mov[i] = 0; end
        chk("mid_rst_val",  32'(val),  0);
        chk("mid_rst_ovf",  32'(ovf),  0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_rdy",  32'(ifc.cmd_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_rdy_early", 32'(ifc.cmd_ready), 0);
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done) dn++;
            if (k == 0) chk("mid_rel_rdy", 32'(ifc.cmd_ready), 1);
        end
        chk("mid_rel_nodone", 32'(dn),  0);
        chk("mid_rel_val",    32'(val), 0);

        // Randomized command mix
        for (int n = 0; n < 60; n++) begin
            op   = int'($urandom_range(0, 7));
            mask = int'($urandom_range(0, (1 << NCH) - 1));
            arg  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, MAXV - 1));
            if (op == 5 || op == 6) begin
                sweep(op, mask, arg, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                      0, 0, $sformatf("rnd%0d_sw", n));
            end else begin
                single(op, mask, arg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $sformatf("rnd%0d", n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
